prbs15_checker: RTL and testbench

PRBS15_CHECKER -- requirements
Module: prbs15_checker

---
 rtl/prbs15_pkg.sv | 29 ++
 rtl/prbs15_checker_popcount15.sv | 16 +
 rtl/prbs15_checker.sv | 150 +++++++++++++++
 tb/tb_prbs15_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs15_pkg.sv
// Shared widths, FSM state type and helpers for the PRBS15 checker.
package prbs15_pkg;

    localparam int PRBS15_W = 15;
    localparam int CNT_W    = 32;
    localparam int POP_W    = 4;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    // x^15 + x^14 + 1, shifting towards the MSB
    function automatic logic [PRBS15_W-1:0] prbs15_next(
        input logic [PRBS15_W-1:0] s
    );
        return {s[PRBS15_W-2:0], s[14] ^ s[13]};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/prbs15_checker_popcount15.sv
// Combinational ones count of a 15-bit word.
module popcount15
    import prbs15_pkg::*;
(
    input  logic [PRBS15_W-1:0] data_i,
    output logic [POP_W-1:0]    count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < PRBS15_W; i++) begin
            count_o = count_o + {{(POP_W-1){1'b0}}, data_i[i]};
        end
    end

endmodule

// File: rtl/prbs15_checker.sv
// PRBS15 sequence checker: self-seeding lock FSM plus saturating
// frame, errored-frame and errored-bit counters.
module prbs15_checker
    import prbs15_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PRBS15_W-1:0] frame_i,
    input  logic                frame_valid_i,
    input  logic                clear_i,
    output logic                locked_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    bit_err_cnt_o,
    output logic [CNT_W-1:0]    frame_err_cnt_o,
    output logic [CNT_W-1:0]    frame_cnt_o
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_V      = MW'(LOCK_CNT);
    localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CNT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_e               state_q, state_d;
    logic [PRBS15_W-1:0]  exp_q, exp_d;
    logic [MW-1:0]        match_q, match_d;
    logic [UW-1:0]        run_q, run_d;
    logic                 clr_q, clr_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     bit_err_cnt_q, bit_err_cnt_d;
    logic [CNT_W-1:0]     frame_err_cnt_q, frame_err_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

    logic [PRBS15_W-1:0]  diff;
    logic [POP_W-1:0]     diff_bits;
    logic                 frame_ok;
    logic                 clr_edge;

    assign diff     = frame_i ^ exp_q;
    assign frame_ok = (diff == '0);
    assign clr_edge = clear_i & ~clr_q;

    popcount15 u_popcount (
        .data_i  (diff),
        .count_o (diff_bits)
    );

    always_comb begin
        state_d         = state_q;
        exp_d           = exp_q;
        match_d         = match_q;
        run_d           = run_q;
        clr_d           = clear_i;
        err_d           = 1'b0;
        bit_err_cnt_d   = bit_err_cnt_q;
        frame_err_cnt_d = frame_err_cnt_q;
        frame_cnt_d     = frame_cnt_q;

        if (clr_edge) begin
            state_d         = ST_UNLOCKED;
            match_d         = '0;
            run_d           = '0;
            bit_err_cnt_d   = '0;
            frame_err_cnt_d = '0;
            frame_cnt_d     = '0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    // lock is declared one cycle after the run completes
                    if (match_q == LOCK_V) begin
                        state_d = ST_LOCKED;
                    end
                    if (frame_valid_i) begin
                        if (frame_i == '0) begin
                            match_d = '0;
                        end else if (match_q == '0 || !frame_ok) begin
                            exp_d   = prbs15_next(frame_i);
                            match_d = MW'(1);
                        end else begin
                            exp_d = prbs15_next(exp_q);
                            if (match_q != LOCK_V) begin
                                match_d = match_q + MW'(1);
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (frame_valid_i) begin
                        // free-running: corrupted frames never reseed exp
                        exp_d       = prbs15_next(exp_q);
                        frame_cnt_d = cnt_sat_add(frame_cnt_q, ONE);
                        if (frame_ok) begin
                            run_d = '0;
                        end else begin
                            err_d         = 1'b1;
                            bit_err_cnt_d = cnt_sat_add(
                                bit_err_cnt_q,
                                {{(CNT_W-POP_W){1'b0}}, diff_bits});
                            frame_err_cnt_d = cnt_sat_add(frame_err_cnt_q, ONE);
                            if (run_q == UNLOCK_LAST) begin
                                state_d = ST_UNLOCKED;
                                match_d = '0;
                                run_d   = '0;
                            end else begin
                                run_d = run_q + UW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_UNLOCKED;
            exp_q           <= '0;
            match_q         <= '0;
            run_q           <= '0;
            clr_q           <= 1'b0;
            err_q           <= 1'b0;
            bit_err_cnt_q   <= '0;
            frame_err_cnt_q <= '0;
            frame_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            exp_q           <= exp_d;
            match_q         <= match_d;
            run_q           <= run_d;
            clr_q           <= clr_d;
            err_q           <= err_d;
            bit_err_cnt_q   <= bit_err_cnt_d;
            frame_err_cnt_q <= frame_err_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    assign locked_o        = (state_q == ST_LOCKED);
    assign err_o           = err_q;
    assign bit_err_cnt_o   = bit_err_cnt_q;
    assign frame_err_cnt_o = frame_err_cnt_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed and randomized bench for prbs15_checker against a behavioural model.
module tb_prbs15_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;
    localparam longint MAXC   = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] frame;
    logic        fv;
    logic        clr;
    logic        locked;
    logic        err;
    logic [31:0] bec;
    logic [31:0] fec;
    logic [31:0] fc;

    always #5 clk = ~clk;

    prbs15_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .frame_i         (frame),
        .frame_valid_i   (fv),
        .clear_i         (clr),
        .locked_o        (locked),
        .err_o           (err),
        .bit_err_cnt_o   (bec),
        .frame_err_cnt_o (fec),
        .frame_cnt_o     (fc)
    );

    int tests  = 0;
    int failed = 0;
    int sn     = 0;

    bit          m_locked, m_err, m_clrq;
    int          m_exp, m_match, m_run;
    longint      m_bits, m_ferr, m_fc;
    logic [14:0] g;
    logic        clr_lvl;

    function automatic int lfsr(input int s);
        return ((s * 2) % 32768) + (((s / 16384) ^ (s / 8192)) % 2);
    endfunction

    function automatic longint sat(input longint v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit r, input bit v, input int f, input bit c);
        bit go;
        if (r) begin
            m_locked = 0; m_err = 0; m_exp = 0; m_match = 0; m_run = 0;
            m_bits = 0; m_ferr = 0; m_fc = 0;
        end else if (c && !m_clrq) begin
            m_err = 0; m_locked = 0; m_match = 0; m_run = 0;
            m_bits = 0; m_ferr = 0; m_fc = 0;
        end else if (!m_locked) begin
            m_err = 0;
            go = (m_match >= LOCK_CNT);
            if (v) begin
                if (f == 0) m_match = 0;
                else if (m_match == 0 || f != m_exp) begin
                    m_exp = lfsr(f); m_match = 1;
                end else begin
                    m_exp = lfsr(m_exp);
                    m_match = (m_match + 1 > LOCK_CNT) ? LOCK_CNT : m_match + 1;
                end
            end
            if (go) m_locked = 1;
        end else begin
            m_err = 0;
            if (v) begin
                m_fc = sat(m_fc + 1);
                if (f != m_exp) begin
                    m_bits = sat(m_bits + $countones(15'(f ^ m_exp)));
                    m_ferr = sat(m_ferr + 1);
                    m_err  = 1;
                    m_run++;
                    if (m_run == UNLOCK_CNT) begin
                        m_locked = 0; m_match = 0; m_run = 0;
                    end
                end else m_run = 0;
                m_exp = lfsr(m_exp);
            end
        end
        m_clrq = r ? 1'b0 : c;
    endtask

    task automatic step(input bit r, input bit v, input logic [14:0] f,
                        input bit c);
        rst = r; fv = v; frame = f; clr = c;
        @(posedge clk);
        model(r, v, int'(f), c);
        #1;
        sn++;
        check($sformatf("s%0d.locked", sn), {31'b0, locked}, {31'b0, m_locked});
        check($sformatf("s%0d.err", sn), {31'b0, err}, {31'b0, m_err});
        check($sformatf("s%0d.bit_err", sn), bec, m_bits[31:0]);
        check($sformatf("s%0d.frame_err", sn), fec, m_ferr[31:0]);
        check($sformatf("s%0d.frame_cnt", sn), fc, m_fc[31:0]);
    endtask

    task automatic good();
        step(0, 1, g, clr_lvl);
        g = 15'(lfsr(int'(g)));
    endtask

    task automatic bad(input logic [14:0] mask);
        step(0, 1, g ^ mask, clr_lvl);
        g = 15'(lfsr(int'(g)));
    endtask

    task automatic idle();
        step(0, 0, 15'($urandom), clr_lvl);
    endtask

    initial begin
        logic [31:0] fc_before;
        logic [14:0] mask;
        int r;
        clr_lvl = 0;
        m_clrq  = 0;
        g       = 15'h0001;

        step(1, 1, 15'h1234, 1);
        step(1, 0, 15'h0000, 0);
        check("reset_locked", {31'b0, locked}, 32'd0);
        check("reset_cnt", fc, 32'd0);

        for (int i = 0; i < 4; i++) good();
        check("no_lock_after4", {31'b0, locked}, 32'd0);
        good();
        check("lock_after5", {31'b0, locked}, 32'd1);
        check("lock_cnt_zero", fc, 32'd0);

        for (int i = 0; i < 5; i++) good();
        bad(15'h0009);
        check("flip2_err", {31'b0, err}, 32'd1);
        check("flip2_bits", bec, 32'd2);
        check("flip2_frames", fec, 32'd1);
        check("flip2_locked", {31'b0, locked}, 32'd1);
        good();
        check("err_one_cycle", {31'b0, err}, 32'd0);

        fc_before = fc;
        for (int i = 0; i < 10; i++) idle();
        check("idle_no_count", fc, fc_before);
        for (int i = 0; i < 6; i++) good();
        check("resume_count", fc, fc_before + 32'd6);

        bad(15'h0100);
        bad(15'h4001);
        check("two_bad_locked", {31'b0, locked}, 32'd1);
        bad(15'h0777);
        check("unlock_after3", {31'b0, locked}, 32'd0);
        for (int i = 0; i < 4; i++) good();
        check("relock_not4", {31'b0, locked}, 32'd0);
        good();
        check("relock_5", {31'b0, locked}, 32'd1);
        for (int i = 0; i < 3; i++) good();

        clr_lvl = 1;
        good();
        check("clear_cnt", fc, 32'd0);
        check("clear_bits", bec, 32'd0);
        check("clear_locked", {31'b0, locked}, 32'd0);
        for (int i = 0; i < 6; i++) good();
        check("clear_held_relock", {31'b0, locked}, 32'd1);
        clr_lvl = 0;
        good();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 3) clr_lvl = ~clr_lvl;
            r = int'($urandom_range(0, 99));
            if (r < 25) idle();
            else if (r < 33) begin
                mask = 15'($urandom_range(1, 32767));
                bad(mask);
            end else if (r < 35) begin
                step(0, 1, 15'h0000, clr_lvl);
                g = 15'(lfsr(int'(g)));
            end else good();
        end
        clr_lvl = 0;

        rst = 1;
        step(1, 1, g, 1);
        check("midreset_locked", {31'b0, locked}, 32'd0);
        check("midreset_cnt", fc, 32'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 15'h0000, 0);
        check("zeros_no_lock", {31'b0, locked}, 32'd0);

        for (int i = 0; i < 6; i++) good();
        check("sat_locked", {31'b0, locked}, 32'd1);
        force dut.bit_err_cnt_q = 32'hFFFF_FFFD;
        m_bits = 64'h0000_0000_FFFF_FFFD;
        #1;
        release dut.bit_err_cnt_q;
        bad(15'h000F);
        check("sat_bits", bec, 32'hFFFF_FFFF);
        good();
        bad(15'h0101);
        check("sat_hold", bec, 32'hFFFF_FFFF);
        good();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
